// File: rtl/data_conv_pkg.sv
// rtl/data_conv_pkg.sv - shared types and constants for the data width converters
// Contents: state_t (IDLE/SEND), BYTE_W (8), WORD_W (32), word_byte() byte selector.
package data_conv_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    b = w[31:24];
    case (idx)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/data_down_conv_if.sv
// rtl/data_down_conv_if.sv - word-in / byte-out handshake bundle for data_down_conv
// Word side: vld_i, data_i[31:0], nbytes_i[1:0] in; rdy_o out.
// Byte side: vld_o, data_o[7:0], last_o out; rdy_i in.
// Modports: slave (converter view), master (environment view).
interface data_down_conv_if;
  import data_conv_pkg::*;

  logic              vld_i;
  logic [WORD_W-1:0] data_i;
  logic [1:0]        nbytes_i;
  logic              rdy_o;
  logic              vld_o;
  logic [BYTE_W-1:0] data_o;
  logic              last_o;
  logic              rdy_i;

  modport slave (
    input  vld_i, data_i, nbytes_i, rdy_i,
    output rdy_o, vld_o, data_o, last_o
  );

  modport master (
    output vld_i, data_i, nbytes_i, rdy_i,
    input  rdy_o, vld_o, data_o, last_o
  );

endinterface

// File: rtl/data_down_conv_skid.sv
// rtl/data_down_conv_skid.sv - one-word holding register for data_down_conv
// Used only when DATA_DOWN_CONV_SKID_EN is defined.
// Ports: clk, rst_n (async active-low); push/pop strobes; word_i/lim_i in;
//        full_o, word_o, lim_o out; rdy_o registered "empty next cycle" flag.
module data_down_conv_skid
  import data_conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        lim_i,
  output logic              full_o,
  output logic [WORD_W-1:0] word_o,
  output logic [1:0]        lim_o,
  output logic              rdy_o
);

  logic              full_q;
  logic              full_d;
  logic              rdy_q;
  logic [WORD_W-1:0] word_q;
  logic [1:0]        lim_q;

  // push only happens while empty and pop only while full, so they never collide.
  assign full_d = push | (full_q & ~pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      word_q <= '0;
      lim_q  <= '0;
    end else begin
      full_q <= full_d;
      // Registered copy of "empty" keeps rdy_o free of any path from rdy_i,
      // and holds it low while in reset.
      rdy_q  <= ~full_d;
      if (push) begin
        word_q <= word_i;
        lim_q  <= lim_i;
      end
    end
  end

  assign full_o = full_q;
  assign word_o = word_q;
  assign lim_o  = lim_q;
  assign rdy_o  = rdy_q;

endmodule

// File: rtl/data_down_conv.sv
// rtl/data_down_conv.sv - 32-bit word to 8-bit byte stream down-converter
// Ports: clk, rst_n (async active-low), bus (data_down_conv_if.slave).
// Each accepted word emits nbytes_i+1 bytes, MSB byte first, last_o on the final one.
// Option: DATA_DOWN_CONV_SKID_EN adds a holding word (data_down_conv_skid) and a
//         registered rdy_o; otherwise rdy_o is combinational from rdy_i.
module data_down_conv
  import data_conv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  data_down_conv_if.slave bus
);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        lim_q, lim_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic              vld;
  logic              take;
  logic              accept;
  logic              at_last;
  logic              load_en;
  logic [WORD_W-1:0] load_word;
  logic [1:0]        load_lim;

  assign vld     = (state_q == SEND);
  assign at_last = (cnt_q == lim_q);
  assign accept  = vld & bus.rdy_i;
  assign take    = bus.vld_i & bus.rdy_o;

`ifdef DATA_DOWN_CONV_SKID_EN
  logic              main_free;
  logic              skid_full;
  logic              skid_push;
  logic              skid_pop;
  logic [WORD_W-1:0] skid_word;
  logic [1:0]        skid_lim;
  logic              skid_rdy;

  // The main register can take a word when idle or when its last byte leaves now.
  assign main_free = (state_q == IDLE) | (accept & at_last);
  // rdy_o tracks the holding register, so take implies it is empty.
  assign skid_push = take & ~main_free;
  assign skid_pop  = skid_full & main_free;
  // A held word is older than anything on the input, so it loads first.
  assign load_en   = main_free & (skid_full | take);
  assign load_word = skid_full ? skid_word : bus.data_i;
  assign load_lim  = skid_full ? skid_lim  : bus.nbytes_i;

  data_down_conv_skid u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (skid_push),
    .pop    (skid_pop),
    .word_i (bus.data_i),
    .lim_i  (bus.nbytes_i),
    .full_o (skid_full),
    .word_o (skid_word),
    .lim_o  (skid_lim),
    .rdy_o  (skid_rdy)
  );

  assign bus.rdy_o = skid_rdy;
`else
  logic alive_q;

  // Keeps rdy_o low during reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  // Ready when empty, or when the last byte is being taken this cycle.
  assign bus.rdy_o = alive_q & ((state_q == IDLE) | (accept & at_last));
  assign load_en   = take;
  assign load_word = bus.data_i;
  assign load_lim  = bus.nbytes_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d = SEND;
          cnt_d   = 2'd0;
          lim_d   = load_lim;
          word_d  = load_word;
        end
      end
      SEND: begin
        if (accept) begin
          if (!at_last) begin
            cnt_d = cnt_q + 2'd1;
          end else if (load_en) begin
            cnt_d  = 2'd0;
            lim_d  = load_lim;
            word_d = load_word;
          end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign bus.vld_o  = vld;
  assign bus.data_o = vld ? word_byte(word_q, cnt_q) : '0;
  assign bus.last_o = vld & at_last;

endmodule
